// File: rtl/shared_adder_arb_pkg.sv
// Shared constants and types for the two-port shared adder with round-robin arbitration.
// Stats counter width applies only when SHARED_ADDER_ARB_STATS_EN is defined.
package shared_adder_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_FULL = 1'b1;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    localparam int STATS_W = 16;

    typedef enum logic {
        IDLE = ST_IDLE,
        FULL = ST_FULL
    } state_t;

endpackage

// File: rtl/multiplexer_N_2to1.sv
// N-bit 2:1 multiplexer used to steer the granted requester's operands into the adder.
module multiplexer_N_2to1 #(
    parameter int N = 4
) (
    input  logic         sel,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    output logic [N-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant plus the priority pointer register.
module rr_arbiter_2
    import shared_adder_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic       grant_valid,
    output logic       grant_id
);

    logic rr_ptr;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = rr_ptr;
        if (enable) begin
            unique case (valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_id    = REQ_ID0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_id    = REQ_ID1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_id    = rr_ptr;
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_id    = rr_ptr;
                end
            endcase
        end
    end

    // A grant is always a transfer, so the loser takes priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= REQ_ID0;
        end else if (grant_valid) begin
            rr_ptr <= ~grant_id;
        end
    end

endmodule

// File: rtl/shared_adder_arbiter_2to1.sv
// One N-bit adder shared by two valid/ready requesters with a registered, backpressured result.
// Optional grant counters and stats_clr are built when SHARED_ADDER_ARB_STATS_EN is defined.
module shared_adder_arbiter_2to1
    import shared_adder_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
`ifdef SHARED_ADDER_ARB_STATS_EN
    input  logic               stats_clr,
    output logic [STATS_W-1:0] grant_cnt0,
    output logic [STATS_W-1:0] grant_cnt1,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_sum,
    output logic         res_cout,
    output logic         res_id
);

    state_t       state, state_nxt;
    logic         slot_free;
    logic         grant_valid;
    logic         grant_id;
    logic         sel_q;
    logic         sel;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N:0]   sum_full;
    logic         transfer;

    // Readys are forced low while reset is held.
    assign slot_free = rst_n && ((state == IDLE) || res_ready);

    rr_arbiter_2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       ({req1_valid, req0_valid}),
        .enable      (slot_free),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign req0_ready = grant_valid && (grant_id == REQ_ID0);
    assign req1_ready = grant_valid && (grant_id == REQ_ID1);
    assign transfer   = grant_valid;

    assign sel = grant_valid ? grant_id : sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= REQ_ID0;
        end else begin
            sel_q <= sel;
        end
    end

    multiplexer_N_2to1 #(.N(N)) u_mux_a (
        .sel (sel),
        .d0  (req0_a),
        .d1  (req1_a),
        .y   (op_a)
    );

    multiplexer_N_2to1 #(.N(N)) u_mux_b (
        .sel (sel),
        .d0  (req0_b),
        .d1  (req1_b),
        .y   (op_b)
    );

    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        state_nxt = state;
        if (transfer) begin
            state_nxt = FULL;
        end else if ((state == FULL) && res_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result register: reloads on any transfer, otherwise holds even after consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_id   <= REQ_ID0;
        end else if (transfer) begin
            res_sum  <= sum_full[N-1:0];
            res_cout <= sum_full[N];
            res_id   <= grant_id;
        end
    end

    assign res_valid = (state == FULL);

`ifdef SHARED_ADDER_ARB_STATS_EN
    // Saturating per-requester transfer counters; a synchronous clear beats a coinciding transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (stats_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_valid && req0_ready && (grant_cnt0 != {STATS_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (req1_valid && req1_ready && (grant_cnt1 != {STATS_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shared_adder_arbiter_2to1.sv
// Directed bench for shared_adder_arbiter_2to1 (N=4); stats checks build when SHARED_ADDER_ARB_STATS_EN is defined.
module tb_shared_adder_arbiter_2to1;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [N-1:0] req1_a, req1_b;
    logic         res_valid, res_ready;
    logic [N-1:0] res_sum;
    logic         res_cout, res_id;
`ifdef SHARED_ADDER_ARB_STATS_EN
    logic         stats_clr;
    logic [15:0]  grant_cnt0, grant_cnt1;
`endif

    int vectors = 0;
    int errors  = 0;

    shared_adder_arbiter_2to1 #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef SHARED_ADDER_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic v, input logic [N-1:0] s,
                             input logic c, input logic id);
        check({tag, ".valid"}, 32'(res_valid), 32'(v));
        check({tag, ".sum"},   32'(res_sum),   32'(s));
        check({tag, ".cout"},  32'(res_cout),  32'(c));
        check({tag, ".id"},    32'(res_id),    32'(id));
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
        res_ready  = 1'b0;
`ifdef SHARED_ADDER_ARB_STATS_EN
        stats_clr  = 1'b0;
`endif
        tick();
        tick();
        // Reset state; readys held low even with a valid request.
        check_res("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        check("reset.req0_ready", 32'(req0_ready), 32'd0);
        check("reset.req1_ready", 32'(req1_ready), 32'd0);

        // Single requester 0: 3+5.
        rst_n     = 1'b1;
        res_ready = 1'b1;
        #1;
        check("single.req0_ready", 32'(req0_ready), 32'd1);
        check("single.req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check_res("single", 1'b1, 4'd8, 1'b0, 1'b0);
        tick();
        check_res("single.consumed", 1'b0, 4'd8, 1'b0, 1'b0);

        // Overflow on requester 1: F+2.
        req1_valid = 1'b1; req1_a = 4'hF; req1_b = 4'h2;
        #1;
        check("ovf.req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check_res("ovf", 1'b1, 4'h1, 1'b1, 1'b1);
        tick();
        check("ovf.consumed", 32'(res_valid), 32'd0);

        // Fairness: both valid, one result per cycle alternating 0,1,...
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i % 2 == 0) check_res($sformatf("fair%0d", i), 1'b1, 4'd2, 1'b0, 1'b0);
            else            check_res($sformatf("fair%0d", i), 1'b1, 4'd4, 1'b0, 1'b1);
        end

        // Backpressure: frozen result and no readys while FULL and not consumed.
        res_ready = 1'b0;
        #1;
        check("bp.req0_ready", 32'(req0_ready), 32'd0);
        check("bp.req1_ready", 32'(req1_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_res($sformatf("bp%0d", i), 1'b1, 4'd4, 1'b0, 1'b1);
            check($sformatf("bp%0d.rdy", i), 32'({req1_ready, req0_ready}), 32'd0);
        end
        res_ready = 1'b1;
        #1;
        check("bp.release.req0_ready", 32'(req0_ready), 32'd1);
        check("bp.release.req1_ready", 32'(req1_ready), 32'd0);
        tick();
        check_res("bp.reload", 1'b1, 4'd2, 1'b0, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check_res("bp.drain", 1'b0, 4'd2, 1'b0, 1'b0);

        // Mid-FULL asynchronous reset, then rr_ptr must be back at requester 0.
        req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd3;
        res_ready  = 1'b0;
        tick();
        req0_valid = 1'b0;
        check_res("prerst", 1'b1, 4'd9, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_res("asyncrst", 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        rst_n      = 1'b1;
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd7;
        #1;
        check("postrst.req0_ready", 32'(req0_ready), 32'd1);
        check("postrst.req1_ready", 32'(req1_ready), 32'd0);
        tick();
        check_res("postrst", 1'b1, 4'd4, 1'b0, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

`ifdef SHARED_ADDER_ARB_STATS_EN
        // Saturation after 70000 requester-0 transfers, then synchronous clear.
        stats_clr = 1'b1;
        tick();
        stats_clr  = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        req0_valid = 1'b0;
        check("stats.cnt0_sat", 32'(grant_cnt0), 32'hFFFF);
        check("stats.cnt1", 32'(grant_cnt1), 32'd0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("stats.clr0", 32'(grant_cnt0), 32'd0);
        check("stats.clr1", 32'(grant_cnt1), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
